// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel-RAM and encoder handshake bundle for ws2812_frame_ctrl.
// WS2812_BRIGHT_EN adds the bright[7:0] brightness input.
interface ws2812_frame_ctrl_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic              busy;
    logic              frame_done;
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;
    logic [23:0]       enc_rgb;
    logic              enc_tx_en;
    logic              enc_tx_done;
`ifdef WS2812_BRIGHT_EN
    logic [7:0]        bright;
`endif

    modport master (
`ifdef WS2812_BRIGHT_EN
        input  bright,
`endif
        input  start, pix_data, enc_tx_done,
        output busy, frame_done, pix_rd_en, pix_addr, enc_rgb, enc_tx_en
    );

    modport slave (
`ifdef WS2812_BRIGHT_EN
        output bright,
`endif
        output start, pix_data, enc_tx_done,
        input  busy, frame_done, pix_rd_en, pix_addr, enc_rgb, enc_tx_en
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: fetches LED_NUM pixels, gates the encoder on word
// boundaries, then holds the latch interval. Option macro: WS2812_BRIGHT_EN.
module ws2812_frame_ctrl #(
    parameter int unsigned LED_NUM      = 64,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned RESET_CYCLES = 15000,
    parameter int unsigned RST_CNT_W    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    ws2812_frame_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        LOAD0,
        ALIGN,
        SEND,
        LATCH
    } state_t;

    localparam logic [ADDR_W+1:0]    NUM      = (ADDR_W+2)'(LED_NUM);
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RESET_CYCLES - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [23:0]          nxt_q, nxt_d;
    logic [23:0]          rgb_q, rgb_d;
    logic                 ld_nxt_q, ld_nxt_d;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 done;
    logic [23:0]          px_in;
    logic [ADDR_W+1:0]    cnt_ext;
    logic                 last_px;
    logic                 more_rd;

`ifdef WS2812_BRIGHT_EN
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        return 8'((17'(c) * 17'({1'b0, b} + 9'd1)) >> 8);
    endfunction

    assign px_in = {scale8(bus.pix_data[23:16], bus.bright),
                    scale8(bus.pix_data[15:8],  bus.bright),
                    scale8(bus.pix_data[7:0],   bus.bright)};
`else
    assign px_in = bus.pix_data;
`endif

    assign cnt_ext = {2'b00, pix_cnt_q};
    assign last_px = (cnt_ext + (ADDR_W+2)'(1)) == NUM;
    assign more_rd = (cnt_ext + (ADDR_W+2)'(2)) < NUM;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        rst_cnt_d = rst_cnt_q;
        rgb_d     = rgb_q;
        nxt_d     = ld_nxt_q ? px_in : nxt_q;
        rd_en     = 1'b0;
        rd_addr   = '0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                pix_cnt_d = '0;
                rst_cnt_d = '0;
                if (bus.start) state_d = FETCH0;
            end
            FETCH0: begin
                rd_en   = 1'b1;
                state_d = LOAD0;
            end
            LOAD0: begin
                rgb_d = px_in;
                if (NUM > (ADDR_W+2)'(1)) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(1);
                end
                state_d = ALIGN;
            end
            ALIGN: begin
                if (bus.enc_tx_done) state_d = SEND;
            end
            SEND: begin
                // Each word boundary swaps in the prefetched pixel and
                // requests the one after it, keeping a single pixel in flight.
                if (bus.enc_tx_done) begin
                    if (last_px) begin
                        state_d = LATCH;
                    end else begin
                        rgb_d     = nxt_q;
                        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                        if (more_rd) begin
                            rd_en   = 1'b1;
                            rd_addr = pix_cnt_q + ADDR_W'(2);
                        end
                    end
                end
            end
            LATCH: begin
                if (rst_cnt_q == RST_LAST) begin
                    done      = 1'b1;
                    rst_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the address-0 read lands directly in enc_rgb; all others go to nxt.
    assign ld_nxt_d = rd_en && (state_q != FETCH0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pix_cnt_q <= '0;
            rst_cnt_q <= '0;
            nxt_q     <= '0;
            rgb_q     <= '0;
            ld_nxt_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            rst_cnt_q <= rst_cnt_d;
            nxt_q     <= nxt_d;
            rgb_q     <= rgb_d;
            ld_nxt_q  <= ld_nxt_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = done;
    assign bus.pix_rd_en  = rd_en;
    assign bus.pix_addr   = rd_addr;
    assign bus.enc_rgb    = rgb_q;
    assign bus.enc_tx_en  = (state_q == SEND);
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Bench for ws2812_frame_ctrl: LED_NUM=4 and LED_NUM=1 instances, free-running
// encoder stub, synchronous RAM model and a frame-level expectation model.
module tb_ws2812_frame_ctrl;
    localparam int N_A   = 4;
    localparam int N_B   = 1;
    localparam int RC    = 100;
    localparam int WORD  = 1512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [10:0] enc_cnt = '0;
    logic [23:0] ram [64];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ws2812_frame_ctrl_if #(.ADDR_W(6)) bus_a ();
    ws2812_frame_ctrl_if #(.ADDR_W(6)) bus_b ();

    ws2812_frame_ctrl #(.LED_NUM(N_A), .ADDR_W(6), .RESET_CYCLES(RC), .RST_CNT_W(16))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    ws2812_frame_ctrl #(.LED_NUM(N_B), .ADDR_W(6), .RESET_CYCLES(RC), .RST_CNT_W(16))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    always @(posedge clk) enc_cnt <= (enc_cnt == 11'(WORD - 1)) ? '0 : enc_cnt + 11'd1;
    assign bus_a.enc_tx_done = (enc_cnt == 11'(WORD - 1));
    assign bus_b.enc_tx_done = (enc_cnt == 11'(WORD - 1));

    always @(posedge clk) begin
        if (bus_a.pix_rd_en) bus_a.pix_data <= ram[bus_a.pix_addr];
        if (bus_b.pix_rd_en) bus_b.pix_data <= ram[bus_b.pix_addr];
    end

    // Observed frame activity
    int           rdq_a[$], rdq_b[$];
    logic [23:0]  wq_a[$], wq_b[$];
    int en_a, en_b, fd_a, fd_b, gap_a, gap_b, rise_bad_a, rise_bad_b;
    int last_en_a, last_en_b;
    logic td_prev = 1'b0, en_prev_a = 1'b0, en_prev_b = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus_a.pix_rd_en) rdq_a.push_back(int'(bus_a.pix_addr));
        if (bus_b.pix_rd_en) rdq_b.push_back(int'(bus_b.pix_addr));
        if (bus_a.enc_tx_en && td_prev) wq_a.push_back(bus_a.enc_rgb);
        if (bus_b.enc_tx_en && td_prev) wq_b.push_back(bus_b.enc_rgb);
        if (bus_a.enc_tx_en) begin
            en_a++; last_en_a = cyc;
            if (!en_prev_a && !td_prev) rise_bad_a++;
        end
        if (bus_b.enc_tx_en) begin
            en_b++; last_en_b = cyc;
            if (!en_prev_b && !td_prev) rise_bad_b++;
        end
        if (bus_a.frame_done) begin fd_a++; gap_a = cyc - last_en_a; end
        if (bus_b.frame_done) begin fd_b++; gap_b = cyc - last_en_b; end
        en_prev_a = bus_a.enc_tx_en;
        en_prev_b = bus_b.enc_tx_en;
        td_prev   = bus_a.enc_tx_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_px(input logic [23:0] p);
`ifdef WS2812_BRIGHT_EN
        int b, r, g, bl;
        b  = int'(bus_a.bright) + 1;
        r  = (int'(p[23:16]) * b) / 256;
        g  = (int'(p[15:8]) * b) / 256;
        bl = (int'(p[7:0]) * b) / 256;
        return {r[7:0], g[7:0], bl[7:0]};
`else
        return p;
`endif
    endfunction

    task automatic clear_logs();
        rdq_a.delete(); rdq_b.delete(); wq_a.delete(); wq_b.delete();
        en_a = 0; en_b = 0; fd_a = 0; fd_b = 0; gap_a = -1; gap_b = -1;
        rise_bad_a = 0; rise_bad_b = 0;
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 64; i++) ram[i] = 24'($urandom);
    endtask

    task automatic pulse_start_a();
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input bit restart);
        bit seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (bus_a.frame_done === 1'b1) begin
                seen = 1'b1;
                if (restart) bus_a.start = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_words_a(input string tag, input int n);
        for (int i = 0; i < 12000 && wq_a.size() < n; i++) @(negedge clk);
        check({tag, "_words_reached"}, 32'(wq_a.size() >= n), 32'd1);
    endtask

    task automatic wait_enc(input int v);
        for (int i = 0; i < 2000 && enc_cnt != 11'(v); i++) @(negedge clk);
    endtask

    task automatic check_frame_a(input string tag);
        check({tag, "_nreads"}, 32'(rdq_a.size()), 32'(N_A));
        for (int i = 0; i < rdq_a.size() && i < N_A; i++)
            check($sformatf("%s_rd%0d", tag, i), 32'(rdq_a[i]), 32'(i));
        check({tag, "_nwords"}, 32'(wq_a.size()), 32'(N_A));
        for (int i = 0; i < wq_a.size() && i < N_A; i++)
            check($sformatf("%s_rgb%0d", tag, i), 32'(wq_a[i]), 32'(exp_px(ram[i])));
        check({tag, "_en_cycles"}, 32'(en_a), 32'(N_A * WORD));
        check({tag, "_rise_align"}, 32'(rise_bad_a), 32'd0);
        check({tag, "_done_count"}, 32'(fd_a), 32'd1);
        check({tag, "_latch_gap"}, 32'(gap_a), 32'(RC));
        check({tag, "_busy_end"}, 32'(bus_a.busy), 32'd0);
        check({tag, "_rgb_hold"}, 32'(bus_a.enc_rgb), 32'(exp_px(ram[N_A-1])));
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
`ifdef WS2812_BRIGHT_EN
        bus_a.bright = 8'd255;
        bus_b.bright = 8'd255;
`endif
        clear_logs();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_done", 32'(bus_a.frame_done), 32'd0);
        check("rst_rd_en", 32'(bus_a.pix_rd_en), 32'd0);
        check("rst_addr", 32'(bus_a.pix_addr), 32'd0);
        check("rst_rgb", 32'(bus_a.enc_rgb), 32'd0);
        check("rst_tx_en", 32'(bus_a.enc_tx_en), 32'd0);
        check("rst_b_tx_en", 32'(bus_b.enc_tx_en), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame on both instances
        fill_ram();
        clear_logs();
        bus_a.start = 1'b1;
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        check("lat_busy", 32'(bus_a.busy), 32'd1);
        check("lat_rd_en", 32'(bus_a.pix_rd_en), 32'd1);
        check("lat_addr", 32'(bus_a.pix_addr), 32'd0);
        wait_done_a("basic", 1'b0);
        check_frame_a("basic");
        check("one_nreads", 32'(rdq_b.size()), 32'd1);
        if (rdq_b.size() > 0) check("one_rd0", 32'(rdq_b[0]), 32'd0);
        check("one_nwords", 32'(wq_b.size()), 32'd1);
        if (wq_b.size() > 0) check("one_rgb0", 32'(wq_b[0]), 32'(exp_px(ram[0])));
        check("one_en_cycles", 32'(en_b), 32'(WORD));
        check("one_rise_align", 32'(rise_bad_b), 32'd0);
        check("one_done_count", 32'(fd_b), 32'd1);
        check("one_latch_gap", 32'(gap_b), 32'(RC));

        // Start during SEND and in the frame_done cycle are both ignored
        fill_ram();
        clear_logs();
        pulse_start_a();
        wait_words_a("busy", 2);
        pulse_start_a();
        wait_done_a("busy", 1'b1);
        check_frame_a("busy");

        // Reset in the middle of SEND, then a clean frame
        fill_ram();
        clear_logs();
        pulse_start_a();
        wait_words_a("mid", 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_tx_en", 32'(bus_a.enc_tx_en), 32'd0);
        check("mid_busy", 32'(bus_a.busy), 32'd0);
        check("mid_rd_en", 32'(bus_a.pix_rd_en), 32'd0);
        check("mid_rgb", 32'(bus_a.enc_rgb), 32'd0);
        @(negedge clk);
        fill_ram();
        clear_logs();
        pulse_start_a();
        wait_done_a("restart", 1'b0);
        check_frame_a("restart");

        // Alignment: start just before and just after a word boundary
        fill_ram();
        clear_logs();
        wait_enc(WORD - 11);
        pulse_start_a();
        wait_done_a("align_pre", 1'b0);
        check_frame_a("align_pre");

        fill_ram();
        clear_logs();
        wait_enc(9);
        pulse_start_a();
        wait_done_a("align_post", 1'b0);
        check_frame_a("align_post");

`ifdef WS2812_BRIGHT_EN
        ram[0] = 24'hFF8040;
        for (int k = 0; k < 3; k++) begin
            logic [23:0] want;
            bus_a.bright = (k == 0) ? 8'd127 : (k == 1) ? 8'd255 : 8'd0;
            want = (k == 0) ? 24'h7F4020 : (k == 1) ? 24'hFF8040 : 24'h000000;
            pulse_start_a();
            repeat (2) @(negedge clk);
            check($sformatf("bright%0d_const", k), 32'(bus_a.enc_rgb), 32'(want));
            check($sformatf("bright%0d_model", k), 32'(bus_a.enc_rgb), 32'(exp_px(ram[0])));
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
        bus_a.bright = 8'd255;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ws2812_frame_ctrl.md
# ws2812_frame_ctrl

Frame sequencer for the WS2812 return-to-zero bit encoder. On a start pulse it reads LED_NUM 24-bit RGB pixels from a synchronous pixel RAM and presents them one at a time on the encoder's RGB input. It gates the encoder's transmit enable so that exactly LED_NUM×24 symbols reach the LED chain, aligned to the encoder's word boundary. It then holds the line low for the latch/reset interval and reports frame completion.

## Interface
- LED_NUM, 64: number of LEDs per frame; legal range 1..2^ADDR_W.
- ADDR_W, 6: pixel RAM address width.
- RESET_CYCLES, 15000: length of the low latch interval in clk cycles (300 µs at 50 MHz).
- RST_CNT_W, 16: width of the latch counter; must hold RESET_CYCLES.

Ports:
- clk  in  1  system clock (50 MHz). This is the only clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  one-cycle request to send one frame. Ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the cycle of frame_done, inclusive.
- frame_done  out  1  one-cycle pulse at the end of the latch interval.
- pix_rd_en  out  1  pixel RAM read strobe.
- pix_addr  out  ADDR_W  pixel RAM address. Valid when pix_rd_en=1.
- pix_data  in  24  pixel RAM read data, {R,G,B}. Valid exactly 1 cycle after pix_rd_en.
- enc_rgb  out  24  pixel to the encoder, {R,G,B}.
- enc_tx_en  out  1  encoder transmit enable.
- enc_tx_done  in  1  encoder end-of-word pulse, one cycle wide. The encoder runs freely, so this pulses every 24 symbol periods (1512 cycles).

## Operation
- Reset values: busy=0, frame_done=0, pix_rd_en=0, pix_addr=0, enc_rgb=0, enc_tx_en=0, state=IDLE. All counters are 0.
- States:
  - IDLE: on start, go to FETCH0.
  - FETCH0: pix_rd_en=1, pix_addr=0.
  - LOAD0:
    - enc_rgb ← pix_data.
    - If LED_NUM>1: pix_rd_en=1, pix_addr=1.
    - Go to ALIGN.
  - ALIGN:
    - Capture pix_data into the prefetch register nxt one cycle after the LOAD0 read.
    - Wait for enc_tx_done, then go to SEND.
    - enc_tx_en rises on the cycle after that pulse.
  - SEND:
    - enc_tx_en=1.
    - pix_cnt counts enc_tx_done pulses received in SEND.
    - On each pulse with pix_cnt<LED_NUM-1:
      - enc_rgb ← nxt and pix_cnt++.
      - If pix_cnt+2<LED_NUM, issue a read of address pix_cnt+2.
      - nxt captures pix_data 1 cycle later.
    - On the pulse with pix_cnt==LED_NUM-1: enc_tx_en←0 (registered), go to LATCH.
  - LATCH:
    - enc_tx_en=0.
    - rst_cnt counts 0..RESET_CYCLES-1.
    - At terminal count: frame_done=1 for one cycle, busy falls on the following cycle, go to IDLE.
- Reads never address ≥LED_NUM. For LED_NUM=1, only address 0 is read and SEND exits on its first enc_tx_done.
- enc_rgb holds its last value after the frame ends; it is not cleared.
- start is not queued. A start in the same cycle as frame_done is ignored.
- A synchronous reset during any state forces all reset values on the next edge. The encoder line goes low within 1 cycle because enc_tx_en=0.

## Timing
- start → pix_rd_en: 1 cycle. start → busy: 1 cycle.
- Frame latency from start: up to 1512 cycles of alignment, then LED_NUM×1512 cycles of SEND, then RESET_CYCLES of LATCH.
- enc_rgb changes only on the cycle after an enc_tx_done pulse (or in LOAD0). It is therefore stable for at least 1511 cycles before the encoder samples it.
- The prefetch of pixel k+1 completes 2 cycles after pixel k is loaded. No stall path is needed.

## Configuration
- WS2812_BRIGHT_EN:
  - When defined, an extra input bright[7:0] is added.
  - Each channel is scaled as c_out = (c × (bright+1)) >> 8, so 8×9-bit products are truncated to 8 bits.
  - bright=255 is identity and bright=0 gives 0.
  - Scaling is applied when a pixel is written into nxt or enc_rgb, so no latency is added.
  - bright is sampled at that same cycle for each pixel.
- When not defined: pix_data passes to enc_rgb unmodified and the bright port does not exist.

## Test plan
- Basic frame, with LED_NUM=4, RESET_CYCLES=100, and an encoder stub pulsing enc_tx_done every 1512 cycles. Stimulus: start. Required response: reads of addresses 0,1,2,3, once each. enc_rgb sequence equals RAM[0..3]. enc_tx_en is high for exactly 4 pulse intervals. frame_done fires exactly 100 cycles after the fall of enc_tx_en.
- LED_NUM=1: required response is a single read of address 0, enc_tx_en high for exactly 1 pulse interval, and no read of address 1.
- Start while busy: a second start issued during SEND is ignored, giving exactly one frame_done. A start in the frame_done cycle produces no new frame.
- Reset mid-SEND: rst_n=0 for 1 cycle at pixel 2. Required response: next cycle enc_tx_en=0, busy=0, state IDLE. A new start afterwards sends the full frame from address 0.
- Alignment: start 10 cycles before an enc_tx_done pulse versus 10 cycles after one. In both cases enc_tx_en rises exactly 1 cycle after a pulse, and no bits are lost.
- WS2812_BRIGHT_EN with pixel 0xFF8040:
  - bright=127 → enc_rgb=0x7F4020.
  - bright=255 → 0xFF8040.
  - bright=0 → 0x000000.
